// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: DEPTH x WIDTH register file, one synchronous write port, two combinational read ports.
// Define REG_FILE_WRITE_BYPASS_EN to forward WD to any read port addressing the word being written.
module reg_file_2r1w #(
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WA,
    input  logic [WIDTH-1:0]  WD,
    input  logic [ADDR_W-1:0] RA1,
    output logic [WIDTH-1:0]  RD1,
    input  logic [ADDR_W-1:0] RA2,
    output logic [WIDTH-1:0]  RD2
);
    localparam int   DEPTH = 2 ** ADDR_W;
    localparam logic ZR    = (ZERO_REG != 0);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            mem_d[i] = (WE && WA == ADDR_W'(i) && !(ZR && i == 0)) ? WD : mem_q[i];
    end
    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= RST ? '0 : mem_d[i];
    end
`ifdef REG_FILE_WRITE_BYPASS_EN
    // Forwarding is suppressed in reset cycles because the write is discarded.
    logic fwd1, fwd2;
    assign fwd1 = WE && !RST && RA1 == WA;
    assign fwd2 = WE && !RST && RA2 == WA;
    assign RD1  = (ZR && RA1 == '0) ? '0 : fwd1 ? WD : mem_q[RA1];
    assign RD2  = (ZR && RA2 == '0) ? '0 : fwd2 ? WD : mem_q[RA2];
`else
    assign RD1  = (ZR && RA1 == '0) ? '0 : mem_q[RA1];
    assign RD2  = (ZR && RA2 == '0) ? '0 : mem_q[RA2];
`endif
endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: randomized and directed checks of reg_file_2r1w against an array model.
// Two instances share stimulus: dut (ZERO_REG=0) and dutz (ZERO_REG=1).
module tb_reg_file_2r1w;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       WE  = 1'b0;
    logic [2:0] WA  = '0;
    logic [7:0] WD  = '0;
    logic [2:0] RA1 = '0;
    logic [2:0] RA2 = '0;
    logic [7:0] RD1, RD2, ZD1, ZD2;
    logic [7:0] mem  [8];
    logic [7:0] memz [8];
    int n_checks = 0;
    int n_fail   = 0;
    logic bypass;

    reg_file_2r1w #(.WIDTH(8), .ADDR_W(3), .ZERO_REG(0)) dut (
        .CLK(CLK), .RST(RST), .WE(WE), .WA(WA), .WD(WD),
        .RA1(RA1), .RD1(RD1), .RA2(RA2), .RD2(RD2)
    );
    reg_file_2r1w #(.WIDTH(8), .ADDR_W(3), .ZERO_REG(1)) dutz (
        .CLK(CLK), .RST(RST), .WE(WE), .WA(WA), .WD(WD),
        .RA1(RA1), .RD1(ZD1), .RA2(RA2), .RD2(ZD2)
    );

    always #5 CLK = ~CLK;

    // Reference: what a read port should show right now, given current inputs.
    function automatic logic [7:0] exp_rd(input logic [2:0] a, input logic zr);
        if (zr && a == 3'd0) return 8'h00;
        if (bypass && WE && !RST && a == WA) return WD;
        return zr ? memz[a] : mem[a];
    endfunction

    task automatic tick();
        @(posedge CLK);
        if (RST) begin
            for (int i = 0; i < 8; i++) begin
                mem[i]  = 8'h00;
                memz[i] = 8'h00;
            end
        end else if (WE) begin
            mem[WA] = WD;
            if (WA != 3'd0) memz[WA] = WD;
        end
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        WE = 1'b1; WA = a; WD = d;
        tick();
        WE = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; tick(); RST = 1'b0;
        for (int i = 0; i < 8; i++) wr(3'(i), 8'hA5);
        RA1 = 3'd2; RA2 = 3'd7; #1;
        n_checks++;
        if (RD1 !== 8'hA5 || RD2 !== 8'hA5) begin
            n_fail++;
            $display("FAIL reset_prefill: RD1=%h RD2=%h expected a5 a5", RD1, RD2);
        end
        RST = 1'b1; tick(); RST = 1'b0;
        for (int i = 0; i < 8; i++) begin
            RA1 = 3'(i); RA2 = 3'(7 - i); #1;
            n_checks++;
            if (RD1 !== 8'h00 || RD2 !== 8'h00 || ZD1 !== 8'h00 || ZD2 !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_clear[%0d]: RD1=%h RD2=%h ZD1=%h ZD2=%h expected 00", i, RD1, RD2, ZD1, ZD2);
            end
        end
    endtask

    task automatic test_write_read();
        wr(3'd3, 8'h11);
        wr(3'd5, 8'h22);
        RA1 = 3'd3; RA2 = 3'd5; #1;
        n_checks++;
        if (RD1 !== 8'h11 || RD2 !== 8'h22) begin
            n_fail++;
            $display("FAIL write_read: RD1=%h RD2=%h expected 11 22", RD1, RD2);
        end
        RA1 = 3'd5; RA2 = 3'd3; #1;
        n_checks++;
        if (RD1 !== 8'h22 || RD2 !== 8'h11) begin
            n_fail++;
            $display("FAIL write_read_swap: RD1=%h RD2=%h expected 22 11", RD1, RD2);
        end
        RA1 = 3'd5; RA2 = 3'd5; #1;
        n_checks++;
        if (RD1 !== 8'h22 || RD2 !== 8'h22) begin
            n_fail++;
            $display("FAIL write_read_same: RD1=%h RD2=%h expected 22 22", RD1, RD2);
        end
    endtask

    task automatic test_gating();
        WE = 1'b0; WA = 3'd2; WD = 8'hFF; tick();
        RA1 = 3'd2; #1;
        n_checks++;
        if (RD1 !== 8'h00) begin
            n_fail++;
            $display("FAIL we_gating: RD1=%h expected 00", RD1);
        end
        wr(3'd4, 8'h99);
        RST = 1'b1; WE = 1'b1; WA = 3'd4; WD = 8'h3C; tick();
        RST = 1'b0; WE = 1'b0;
        RA1 = 3'd4; RA2 = 3'd3; #1;
        n_checks++;
        if (RD1 !== 8'h00 || RD2 !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_priority: RD1=%h RD2=%h expected 00 00", RD1, RD2);
        end
    endtask

    task automatic test_read_during_write();
        wr(3'd6, 8'h10);
        WE = 1'b1; WA = 3'd6; WD = 8'h20; RA1 = 3'd6; RA2 = 3'd1; #1;
        n_checks++;
        if (RD1 !== (bypass ? 8'h20 : 8'h10) || RD2 !== 8'h00) begin
            n_fail++;
            $display("FAIL rdw_before: RD1=%h RD2=%h expected %h 00", RD1, RD2, bypass ? 8'h20 : 8'h10);
        end
        tick(); WE = 1'b0; #1;
        n_checks++;
        if (RD1 !== 8'h20) begin
            n_fail++;
            $display("FAIL rdw_after: RD1=%h expected 20", RD1);
        end
    endtask

    task automatic test_zero_reg();
        wr(3'd0, 8'h77);
        wr(3'd1, 8'h77);
        RA1 = 3'd0; RA2 = 3'd1; #1;
        n_checks++;
        if (ZD1 !== 8'h00 || ZD2 !== 8'h77) begin
            n_fail++;
            $display("FAIL zero_reg: ZD1=%h ZD2=%h expected 00 77", ZD1, ZD2);
        end
        n_checks++;
        if (RD1 !== 8'h77 || RD2 !== 8'h77) begin
            n_fail++;
            $display("FAIL zero_reg_off: RD1=%h RD2=%h expected 77 77", RD1, RD2);
        end
    endtask

    task automatic test_reset_mid_sequence();
        wr(3'd7, 8'h5A);
        RA1 = 3'd7; #1;
        n_checks++;
        if (RD1 !== 8'h5A) begin
            n_fail++;
            $display("FAIL mid_write_landed: RD1=%h expected 5a", RD1);
        end
        RST = 1'b1; tick(); RST = 1'b0; #1;
        n_checks++;
        if (RD1 !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset_clear: RD1=%h expected 00", RD1);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int c = 0; c < 1000; c++) begin
            RST = ($urandom_range(31) == 0);
            WE  = $urandom_range(1);
            WA  = 3'($urandom_range(7));
            WD  = 8'($urandom);
            RA1 = ($urandom_range(3) == 0) ? WA : 3'($urandom_range(7));
            RA2 = ($urandom_range(3) == 0) ? RA1 : 3'($urandom_range(7));
            #1;
            n_checks++;
            if (RD1 !== exp_rd(RA1, 1'b0) || RD2 !== exp_rd(RA2, 1'b0) ||
                ZD1 !== exp_rd(RA1, 1'b1) || ZD2 !== exp_rd(RA2, 1'b1)) begin
                n_fail++;
                if (errs++ < 10)
                    $display("FAIL random[%0d]: RD1=%h/%h RD2=%h/%h ZD1=%h/%h ZD2=%h/%h (got/expected)",
                             c, RD1, exp_rd(RA1, 1'b0), RD2, exp_rd(RA2, 1'b0),
                             ZD1, exp_rd(RA1, 1'b1), ZD2, exp_rd(RA2, 1'b1));
            end
            tick();
        end
        RST = 1'b0; WE = 1'b0;
    endtask

    initial begin
`ifdef REG_FILE_WRITE_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        for (int i = 0; i < 8; i++) begin
            mem[i]  = 8'h00;
            memz[i] = 8'h00;
        end
        @(negedge CLK);
        test_reset();
        test_write_read();
        test_gating();
        test_read_during_write();
        test_zero_reg();
        test_reset_mid_sequence();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
